// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with one handshaked write port,
// N_RD independent registered read ports, write-first bypass, out-of-range
// flagging and a one-entry-per-cycle clear engine.
module regfile_mp #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 12,
   parameter int ADDR_W = 4,
   parameter int N_RD   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     wr_err,
   input  logic [N_RD-1:0]          rd_en,
   input  logic [N_RD*ADDR_W-1:0]   rd_addr,
   output logic [N_RD*DATA_W-1:0]   rd_data,
   output logic [N_RD-1:0]          rd_valid,
   output logic [N_RD-1:0]          rd_err,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     clr_done
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   ptr, ptr_nx;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                wr_acc;
   logic                wr_in;
   logic                clr_wr;

   assign wr_ready = (state == IDLE) & ~clr_req;
   assign wr_acc   = wr_valid & wr_ready;
   assign wr_in    = ({1'b0, wr_addr} < DEPTH_C);
   assign clr_wr   = (state == CLEAR);
   assign busy     = (state == CLEAR);

   // Next-state logic: clear request wins over a same-cycle write.
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nx = CLEAR;
               ptr_nx   = '0;
            end
         end
         CLEAR: begin
            if (ptr == LAST) begin
               state_nx = IDLE;
               ptr_nx   = '0;
            end else begin
               ptr_nx = ptr + ADDR_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            ptr_nx   = '0;
         end
      endcase
   end

   // State, clear pointer and the one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         wr_err   <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         wr_err   <= wr_acc & ~wr_in;
         clr_done <= (state == CLEAR) && (ptr == LAST);
      end
   end

   // Storage: accepted in-range writes, or the clear engine zeroing one entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_acc && wr_in) begin
         mem[wr_addr] <= wr_data;
      end else if (clr_wr) begin
         mem[ptr] <= '0;
      end
   end

   for (genvar g = 0; g < N_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              oor;
      logic              hit_wr;
      logic              hit_clr;
      logic [DATA_W-1:0] d_nx;
      logic [DATA_W-1:0] d_q;
      logic              v_q;
      logic              e_q;

      assign ra      = rd_addr[g*ADDR_W +: ADDR_W];
      assign oor     = ({1'b0, ra} >= DEPTH_C);
      assign hit_wr  = wr_acc & wr_in & (wr_addr == ra);
      assign hit_clr = clr_wr & (ptr == ra);

      // Read mux: out-of-range reads return zero; same-edge writes bypass storage.
      always_comb begin
         d_nx = '0;
         if (oor) begin
            d_nx = '0;
         end else if (hit_wr) begin
            d_nx = wr_data;
         end else if (hit_clr) begin
            d_nx = '0;
         end else begin
            d_nx = mem[ra];
         end
      end

      // Registered read outputs; data holds when the port is not strobed.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            d_q <= '0;
            v_q <= 1'b0;
            e_q <= 1'b0;
         end else begin
            v_q <= rd_en[g];
            e_q <= rd_en[g] & oor;
            if (rd_en[g]) begin
               d_q <= d_nx;
            end
         end
      end

      assign rd_data[g*DATA_W +: DATA_W] = d_q;
      assign rd_valid[g]                 = v_q;
      assign rd_err[g]                   = e_q;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven, hand-sequenced and randomized checks of
// regfile_mp against an array-based reference model.
module tb_regfile_mp;

   localparam int DEPTH = 12;

   logic        clk;
   logic        rst_n;
   logic        wr_valid;
   logic        wr_ready;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        wr_err;
   logic [1:0]  rd_en;
   logic [7:0]  rd_addr;
   logic [15:0] rd_data;
   logic [1:0]  rd_valid;
   logic [1:0]  rd_err;
   logic        clr_req;
   logic        busy;
   logic        clr_done;

   int errs;
   int checks;

   // Reference model: storage array plus clear progress counter.
   logic [7:0] mdl [DEPTH];
   bit         m_clr;
   int         m_cnt;
   logic [7:0] e_d [2];
   bit         e_v [2];
   bit         e_e [2];
   bit         e_we;
   bit         e_done;

   regfile_mp #(.DATA_W(8), .DEPTH(12), .ADDR_W(4), .N_RD(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_err(wr_err),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_err(rd_err),
      .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_en    = '0;
      rd_addr  = '0;
      clr_req  = 1'b0;
   endtask

   task automatic check_outputs();
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("rd_valid%0d", p), 32'(rd_valid[p]), 32'(e_v[p]));
         chk($sformatf("rd_err%0d", p), 32'(rd_err[p]), 32'(e_e[p]));
         chk($sformatf("rd_data%0d", p), 32'(rd_data[p*8 +: 8]), 32'(e_d[p]));
      end
      chk("wr_err", 32'(wr_err), 32'(e_we));
      chk("busy", 32'(busy), 32'(m_clr));
      chk("clr_done", 32'(clr_done), 32'(e_done));
   endtask

   // Apply the currently driven inputs for one clock edge and check the result.
   task automatic cycle();
      bit         acc;
      logic [3:0] a;
      #1;
      chk("wr_ready", 32'(wr_ready), 32'(!m_clr && !clr_req));
      acc    = wr_valid && !m_clr && !clr_req;
      e_we   = acc && (int'(wr_addr) >= DEPTH);
      e_done = 1'b0;
      if (acc && int'(wr_addr) < DEPTH) mdl[wr_addr] = wr_data;
      if (m_clr) begin
         mdl[m_cnt] = '0;
         m_cnt++;
         if (m_cnt == DEPTH) begin
            m_clr  = 1'b0;
            e_done = 1'b1;
         end
      end else if (clr_req) begin
         m_clr = 1'b1;
         m_cnt = 0;
      end
      // Write-first: reads observe storage after this edge's update.
      for (int p = 0; p < 2; p++) begin
         a = rd_addr[p*4 +: 4];
         e_v[p] = rd_en[p];
         e_e[p] = 1'b0;
         if (rd_en[p]) begin
            if (int'(a) >= DEPTH) begin
               e_d[p] = '0;
               e_e[p] = 1'b1;
            end else begin
               e_d[p] = mdl[a];
            end
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      m_clr  = 1'b0;
      m_cnt  = 0;
      e_we   = 1'b0;
      e_done = 1'b0;
      for (int p = 0; p < 2; p++) begin
         e_d[p] = '0;
         e_v[p] = 1'b0;
         e_e[p] = 1'b0;
      end
   endtask

   // Asynchronous reset asserted between edges; outputs checked before any edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      check_outputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH; i++) begin
         idle_inputs();
         rd_en   = 2'b11;
         rd_addr = {4'(DEPTH-1-i), 4'(i)};
         cycle();
      end
   endtask

   typedef struct {
      logic       wv;
      logic [3:0] wa;
      logic [7:0] wd;
      logic [1:0] re;
      logic [3:0] ra0;
      logic [3:0] ra1;
      logic [1:0] xv;
      logic [1:0] xe;
      logic [7:0] xd0;
      logic [7:0] xd1;
      logic       xwe;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int n_busy;
      bit seen_done;

      errs   = 0;
      checks = 0;
      idle_inputs();
      rst_n  = 1'b0;
      #3;
      do_reset();

      // Reset then read every entry on port 0.
      for (int i = 0; i < DEPTH; i++) begin
         idle_inputs();
         rd_en   = 2'b01;
         rd_addr = {4'd0, 4'(i)};
         cycle();
         chk("reset_read_data", 32'(rd_data[7:0]), 32'h00);
         chk("reset_read_valid", 32'(rd_valid[0]), 32'd1);
      end

      // Bypass, dual-port and out-of-range vectors with expected outputs.
      tbl[0]  = '{1'b1, 4'd3,  8'hA5, 2'b10, 4'd0,  4'd3,  2'b10, 2'b00, 8'h00, 8'hA5, 1'b0};
      tbl[1]  = '{1'b0, 4'd0,  8'h00, 2'b01, 4'd3,  4'd0,  2'b01, 2'b00, 8'hA5, 8'hA5, 1'b0};
      tbl[2]  = '{1'b1, 4'd2,  8'h11, 2'b00, 4'd0,  4'd0,  2'b00, 2'b00, 8'hA5, 8'hA5, 1'b0};
      tbl[3]  = '{1'b1, 4'd7,  8'h77, 2'b00, 4'd0,  4'd0,  2'b00, 2'b00, 8'hA5, 8'hA5, 1'b0};
      tbl[4]  = '{1'b0, 4'd0,  8'h00, 2'b11, 4'd2,  4'd7,  2'b11, 2'b00, 8'h11, 8'h77, 1'b0};
      tbl[5]  = '{1'b0, 4'd0,  8'h00, 2'b11, 4'd7,  4'd7,  2'b11, 2'b00, 8'h77, 8'h77, 1'b0};
      tbl[6]  = '{1'b1, 4'd13, 8'hFF, 2'b00, 4'd0,  4'd0,  2'b00, 2'b00, 8'h77, 8'h77, 1'b1};
      tbl[7]  = '{1'b0, 4'd0,  8'h00, 2'b01, 4'd15, 4'd0,  2'b01, 2'b01, 8'h00, 8'h77, 1'b0};
      tbl[8]  = '{1'b0, 4'd0,  8'h00, 2'b11, 4'd13, 4'd3,  2'b11, 2'b01, 8'h00, 8'hA5, 1'b0};
      tbl[9]  = '{1'b0, 4'd0,  8'h00, 2'b10, 4'd0,  4'd12, 2'b10, 2'b10, 8'h00, 8'h00, 1'b0};
      tbl[10] = '{1'b0, 4'd0,  8'h00, 2'b01, 4'd11, 4'd0,  2'b01, 2'b00, 8'h00, 8'h00, 1'b0};
      tbl[11] = '{1'b1, 4'd11, 8'hC3, 2'b11, 4'd11, 4'd11, 2'b11, 2'b00, 8'hC3, 8'hC3, 1'b0};

      for (int i = 0; i < 12; i++) begin
         idle_inputs();
         wr_valid = tbl[i].wv;
         wr_addr  = tbl[i].wa;
         wr_data  = tbl[i].wd;
         rd_en    = tbl[i].re;
         rd_addr  = {tbl[i].ra1, tbl[i].ra0};
         cycle();
         chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].xv));
         chk($sformatf("tbl%0d_err", i), 32'(rd_err), 32'(tbl[i].xe));
         chk($sformatf("tbl%0d_d0", i), 32'(rd_data[7:0]), 32'(tbl[i].xd0));
         chk($sformatf("tbl%0d_d1", i), 32'(rd_data[15:8]), 32'(tbl[i].xd1));
         chk($sformatf("tbl%0d_wr_err", i), 32'(wr_err), 32'(tbl[i].xwe));
      end

      // Clear: fill with 0x5A, then clr_req together with a write to addr 0.
      for (int i = 0; i < DEPTH; i++) begin
         idle_inputs();
         wr_valid = 1'b1;
         wr_addr  = 4'(i);
         wr_data  = 8'h5A;
         cycle();
      end
      idle_inputs();
      clr_req  = 1'b1;
      wr_valid = 1'b1;
      wr_addr  = 4'd0;
      wr_data  = 8'h33;
      #1;
      chk("clr_wr_ready", 32'(wr_ready), 32'd0);
      cycle();
      n_busy    = busy ? 1 : 0;
      seen_done = 1'b0;
      for (int k = 0; k < 20 && !seen_done; k++) begin
         idle_inputs();
         rd_en   = 2'b11;
         rd_addr = {4'd11, 4'd0};
         cycle();
         chk("clr_rd0_zero", 32'(rd_data[7:0]), 32'h00);
         if (busy) begin
            n_busy++;
            chk("clr_rd11_old", 32'(rd_data[15:8]), 32'h5A);
         end
         if (clr_done) begin
            seen_done = 1'b1;
            chk("clr_rd11_bypass", 32'(rd_data[15:8]), 32'h00);
         end
      end
      chk("clr_done_seen", 32'(seen_done), 32'd1);
      chk("clr_busy_cycles", 32'(n_busy), 32'd12);
      read_all();

      // Reset mid-clear at clear cycle 5.
      for (int i = 0; i < DEPTH; i++) begin
         idle_inputs();
         wr_valid = 1'b1;
         wr_addr  = 4'(i);
         wr_data  = 8'(8'h40 + i);
         cycle();
      end
      idle_inputs();
      clr_req = 1'b1;
      cycle();
      idle_inputs();
      for (int k = 0; k < 4; k++) cycle();
      chk("midclr_busy_before", 32'(busy), 32'd1);
      do_reset();
      chk("midclr_busy_after", 32'(busy), 32'd0);
      chk("midclr_wr_ready", 32'(wr_ready), 32'd1);
      for (int k = 0; k < 14; k++) begin
         cycle();
         chk("midclr_no_done", 32'(clr_done), 32'd0);
      end
      read_all();

      // Randomized traffic against the reference model.
      for (int k = 0; k < 400; k++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_addr  = 4'($urandom_range(0, 15));
         wr_data  = 8'($urandom);
         rd_en    = 2'($urandom_range(0, 3));
         rd_addr  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rd_addr[7:4] = wr_addr;
         clr_req  = ($urandom_range(0, 29) == 0);
         cycle();
      end
      idle_inputs();
      for (int k = 0; k < 14; k++) cycle();
      read_all();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
